// File: rtl/mult_accumulator_pkg.sv
// Shared types and width helpers for the multiply-accumulate consumer.
package mult_accumulator_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned LATENCY_DEF = 3;
    localparam int unsigned GUARD_DEF   = 8;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [1:0] {
        ACCEPT,
        DRAIN,
        HOLD
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    // Accumulator holds a 2*width product plus guard bits of headroom.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned guard);
        return 2 * width + guard;
    endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register of beat tags, aligned with the multiplier pipeline.
module tag_delay_line
    import mult_accumulator_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  tag_t                 tag_in,
    output tag_t [DEPTH-1:0]     taps
);

    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= '0;
        end else begin
            taps[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/mult_accumulator.sv
// Feeds operand pairs to an external non-stalling multiplier and sums each
// frame's products into a guarded accumulator, one result per frame.
module mult_accumulator
    import mult_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter int unsigned GUARD   = GUARD_DEF,
    localparam int unsigned ACC_W  = acc_width(WIDTH, GUARD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_acc,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_overflow,
    output logic                 busy
);

    localparam int unsigned SUM_W = ACC_W + 1;

    state_t                state;
    state_t                state_next;
    tag_t                  tag_in;
    tag_t [LATENCY-1:0]    taps;
    tag_t                  tail;
    logic                  accept;
    logic                  busy_next;
    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  ovf;
    logic [SUM_W-1:0]      sum;

    // The multiplier sees the offered operands directly; tags decide what counts.
    assign mul_a   = in_a;
    assign mul_b   = in_b;
    assign accept  = in_valid & in_ready;
    assign tail    = taps[LATENCY-1];
    assign sum     = {1'b0, acc} + SUM_W'(mul_y);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        tag_in       = '0;
        tag_in.valid = accept;
        tag_in.last  = accept & in_last;
    end

    tag_delay_line #(
        .DEPTH (LATENCY)
    ) u_tags (
        .clk    (clk),
        .rst    (rst),
        .tag_in (tag_in),
        .taps   (taps)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_next  = 1'b0;
        unique case (state)
            ACCEPT:  if (accept && in_last)         state_next = DRAIN;
            DRAIN:   if (tail.valid && tail.last)   state_next = HOLD;
            HOLD:    if (out_ready)                 state_next = ACCEPT;
            default:                                state_next = ACCEPT;
        endcase
        // Look one cycle ahead so busy can be a plain register.
        busy_next = (state_next == HOLD) | tag_in.valid;
        for (int unsigned i = 0; i + 1 < LATENCY; i++) begin
            busy_next = busy_next | taps[i].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_next == ACCEPT);
            out_valid <= (state_next == HOLD);
            busy      <= busy_next;
        end
    end

    // Products are only meaningful when the tail tag marks an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_acc      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (tail.valid) begin
            if (tail.last) begin
                out_acc      <= sum[ACC_W-1:0];
                out_count    <= cnt_inc;
                out_overflow <= ovf | sum[ACC_W];
                acc          <= '0;
                cnt          <= '0;
                ovf          <= 1'b0;
            end else begin
                acc <= sum[ACC_W-1:0];
                cnt <= cnt_inc;
                ovf <= ovf | sum[ACC_W];
            end
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: behavioural multiplier pipeline plus a frame-sum
// reference computed with exact wide arithmetic.
module tb_mult_accumulator;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned GUARD   = 8;
    localparam int unsigned ACC_W   = 2 * WIDTH + GUARD;
    localparam int unsigned BIG_W   = ACC_W + 17;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } beat_t;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [15:0]      count;
        logic             ovf;
    } res_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a = '0;
    logic [WIDTH-1:0]   in_b = '0;
    logic               in_last = 1'b0;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_y;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [ACC_W-1:0]   out_acc;
    logic [15:0]        out_count;
    logic               out_overflow;
    logic               busy;

    logic [2*WIDTH-1:0] pipe [LATENCY];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: captures at the edge, result after LATENCY-1 more edges.
    always @(posedge clk) begin
        pipe[0] <= (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
        for (int i = 1; i < int'(LATENCY); i++) pipe[i] <= pipe[i-1];
    end
    assign mul_y = pipe[LATENCY-1];

    mult_accumulator #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .GUARD   (GUARD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_last      (in_last),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_y        (mul_y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_acc      (out_acc),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    function automatic beat_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        beat_t bt;
        bt.a = a;
        bt.b = b;
        return bt;
    endfunction

    // Exact frame sum; the accumulator keeps the low ACC_W bits, anything above is overflow.
    function automatic res_t model(input beat_t q[$]);
        logic [BIG_W-1:0] total = '0;
        res_t r;
        foreach (q[i]) total = total + BIG_W'(q[i].a) * BIG_W'(q[i].b);
        r.acc   = total[ACC_W-1:0];
        r.ovf   = (total >> ACC_W) != '0;
        r.count = (q.size() > 65535) ? 16'hFFFF : 16'(q.size());
        return r;
    endfunction

    task automatic drive_beat(input beat_t bt, input logic last, output int acc_edge);
        int   guard = 0;
        logic rdy   = 1'b0;
        in_valid = 1'b1;
        in_a     = bt.a;
        in_b     = bt.b;
        in_last  = last;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 200);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        acc_edge = cyc;
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", rdy, guard);
        end
    endtask

    task automatic send_frame(input beat_t q[$], input int max_gap, output int last_edge);
        last_edge = 0;
        foreach (q[i]) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_beat(q[i], i == q.size() - 1, last_edge);
        end
    endtask

    task automatic wait_result(output bit found, output int edge_no, output res_t r);
        found   = 1'b0;
        edge_no = 0;
        r.acc   = '0;
        r.count = '0;
        r.ovf   = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (out_valid) begin
                found   = 1'b1;
                edge_no = cyc;
                r.acc   = out_acc;
                r.count = out_count;
                r.ovf   = out_overflow;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        in_a = 32'h1234_5678;
        in_b = 32'h9ABC_DEF0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, out_overflow} !== 4'b0000 || out_acc !== '0 || out_count !== '0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b ov=%b busy=%b ovf=%b acc=%h cnt=%h, required all zero",
                     in_ready, out_valid, busy, out_overflow, out_acc, out_count);
        end
        checks++;
        if (mul_a !== in_a || mul_b !== in_b) begin
            failures++;
            $display("FAIL mul_passthru: mul_a=%h mul_b=%h, required %h %h", mul_a, mul_b, in_a, in_b);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_reset: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_single_frame();
        beat_t q[$];
        res_t  exp, got;
        bit    found;
        int    le, oe;
        q.push_back(mk(32'd3, 32'd5));
        q.push_back(mk(32'd7, 32'd11));
        q.push_back(mk(32'd2, 32'd2));
        exp = model(q);
        out_ready = 1'b1;
        send_frame(q, 0, le);
        wait_result(found, oe, got);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL single_timeout: out_valid never rose, required 1");
        end
        checks++;
        if (got.acc !== exp.acc || got.count !== exp.count || got.ovf !== exp.ovf) begin
            failures++;
            $display("FAIL single_result: acc=%0d cnt=%0d ovf=%b, required %0d %0d %b",
                     got.acc, got.count, got.ovf, exp.acc, exp.count, exp.ovf);
        end
        checks++;
        if (oe - le != int'(LATENCY)) begin
            failures++;
            $display("FAIL single_latency: %0d edges, required %0d", oe - le, LATENCY);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse: out_valid=%b after handshake, required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        beat_t q[$];
        res_t  exp, got;
        bit    found;
        bit    bad = 1'b0;
        int    le, oe;
        q.push_back(mk('1, '1));
        exp = model(q);
        out_ready = 1'b0;
        send_frame(q, 0, le);
        wait_result(found, oe, got);
        checks++;
        if (!found || got.acc !== exp.acc || got.count !== 16'd1) begin
            failures++;
            $display("FAIL bp_result: found=%b acc=%h cnt=%0d, required 1 %h 1", found, got.acc, got.count, exp.acc);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_acc !== exp.acc || out_count !== 16'd1 || in_ready !== 1'b0)
                bad = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL bp_hold: ov=%b acc=%h rdy=%b, required 1 %h 0", out_valid, out_acc, in_ready, exp.acc);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: ov=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        beat_t q[$];
        beat_t q2[$];
        res_t  exp, got;
        bit    found;
        int    le, oe;
        for (int i = 0; i < 257; i++) q.push_back(mk('1, '1));
        exp = model(q);
        out_ready = 1'b1;
        send_frame(q, 0, le);
        wait_result(found, oe, got);
        checks++;
        if (!found || got.ovf !== 1'b1 || got.acc !== exp.acc || got.count !== exp.count) begin
            failures++;
            $display("FAIL ovf_frame: found=%b ovf=%b acc=%h cnt=%0d, required 1 1 %h %0d",
                     found, got.ovf, got.acc, got.count, exp.acc, exp.count);
        end
        q2.push_back(mk(32'd1, 32'd1));
        exp = model(q2);
        send_frame(q2, 0, le);
        wait_result(found, oe, got);
        checks++;
        if (!found || got.acc !== exp.acc || got.ovf !== 1'b0 || got.count !== 16'd1) begin
            failures++;
            $display("FAIL ovf_cleared: acc=%h ovf=%b cnt=%0d, required %h 0 1", got.acc, got.ovf, got.count, exp.acc);
        end
    endtask

    task automatic test_gapped();
        beat_t q[$];
        res_t  exp, got;
        bit    found;
        int    le, oe;
        for (int i = 1; i <= 8; i++) q.push_back(mk(WIDTH'(i), WIDTH'(i)));
        exp = model(q);
        out_ready = 1'b1;
        send_frame(q, 3, le);
        wait_result(found, oe, got);
        checks++;
        if (!found || got.acc !== exp.acc || got.count !== 16'd8 || got.ovf !== 1'b0) begin
            failures++;
            $display("FAIL gapped: acc=%0d cnt=%0d ovf=%b, required %0d 8 0", got.acc, got.count, got.ovf, exp.acc);
        end
    endtask

    task automatic test_reset_mid();
        beat_t q[$];
        res_t  exp, got;
        bit    found;
        bit    bad = 1'b0;
        int    le, oe;
        out_ready = 1'b1;
        drive_beat(mk(32'd5, 32'd6), 1'b0, le);
        drive_beat(mk(32'd7, 32'd8), 1'b0, le);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: ov=%b busy=%b, required 0 0", out_valid, busy);
        end
        for (int i = 0; i < int'(LATENCY) + 2; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL midreset_quiet: ov=%b busy=%b, required 0 0", out_valid, busy);
        end
        q.push_back(mk(32'd4, 32'd4));
        exp = model(q);
        send_frame(q, 0, le);
        wait_result(found, oe, got);
        checks++;
        if (!found || got.acc !== exp.acc || got.count !== 16'd1 || got.ovf !== 1'b0) begin
            failures++;
            $display("FAIL midreset_next: acc=%0d cnt=%0d, required %0d 1", got.acc, got.count, exp.acc);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 20; f++) begin
            beat_t q[$];
            res_t  exp, got;
            bit    found;
            bit    bad = 1'b0;
            int    le, oe;
            int    n = int'($urandom_range(6, 1));
            bit    hold = $urandom_range(1, 0) == 1;
            for (int i = 0; i < n; i++) q.push_back(mk($urandom, $urandom));
            exp = model(q);
            out_ready = !hold;
            send_frame(q, 2, le);
            wait_result(found, oe, got);
            checks++;
            if (!found || got.acc !== exp.acc || got.count !== exp.count || got.ovf !== exp.ovf) begin
                failures++;
                $display("FAIL rand_frame%0d: acc=%h cnt=%0d ovf=%b, required %h %0d %b",
                         f, got.acc, got.count, got.ovf, exp.acc, exp.count, exp.ovf);
            end
            if (hold) begin
                repeat ($urandom_range(3, 1)) begin
                    @(negedge clk);
                    if (out_valid !== 1'b1 || out_acc !== exp.acc) bad = 1'b1;
                    @(posedge clk);
                    #1;
                end
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL rand_hold%0d: ov=%b acc=%h, required 1 %h", f, out_valid, out_acc, exp.acc);
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1;
            end
        end
    endtask

    // One idle gap of LATENCY+1 cycles separates consecutive single-beat frames.
    task automatic test_throughput();
        int prev = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            beat_t q[$];
            res_t  exp, got;
            bit    found;
            int    le, oe;
            q.push_back(mk($urandom, $urandom));
            exp = model(q);
            send_frame(q, 0, le);
            if (k > 0) begin
                checks++;
                if (le - prev != int'(LATENCY) + 2) begin
                    failures++;
                    $display("FAIL tput_period%0d: %0d edges between accepts, required %0d", k, le - prev, LATENCY + 2);
                end
            end
            prev = le;
            wait_result(found, oe, got);
            checks++;
            if (!found || got.acc !== exp.acc || got.count !== 16'd1) begin
                failures++;
                $display("FAIL tput_result%0d: acc=%h cnt=%0d, required %h 1", k, got.acc, got.count, exp.acc);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_gapped();
        test_reset_mid();
        test_random_frames();
        test_throughput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
